// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// read-response codes and the default reset PC.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch-unit performance counters: delivered instructions and memory stall
// cycles. Both are 64-bit and wrap naturally. Only instantiated when
// IFU_PERF_CNT_EN is defined.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [63:0] perf_stall_cnt_o
);

    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    // Increment each counter on its strobe
    always_comb begin
        fetch_cnt_d = fetch_inc_i ? fetch_cnt_q + 64'd1 : fetch_cnt_q;
        stall_cnt_d = stall_inc_i ? stall_cnt_q + 64'd1 : stall_cnt_q;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage feeding the IF/ID register. Owns the PC, keeps one
// read outstanding, holds the fetched {pc, inst} until the IF/ID register
// accepts it, and handles redirects. Optional performance counters are
// enabled with the IFU_PERF_CNT_EN macro.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              arvalid_o,
    output logic [ADDR_W-1:0] araddr_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    output logic              rready_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              fetch_err_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetch_cnt_o,
    output logic [63:0]       perf_stall_cnt_o
`endif
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              kill_q, kill_d;
    logic              err_q, err_d;
    logic              accept;
    logic [1:0]        unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = ADDR;
            ADDR: if (arready_i) state_d = DATA;
            DATA: if (rvalid_i) state_d = (kill_q || redirect_i) ? ADDR : HOLD;
            HOLD: if (inst_ready_i || redirect_i) state_d = ADDR;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        arvalid_o    = (state_q == ADDR);
        rready_o     = (state_q == DATA);
        inst_valid_o = (state_q == HOLD);
    end

    // Datapath next values: PC, kill flag, request address, held instruction.
    // The request address is captured separately from the PC so that a
    // redirect while in ADDR cannot move araddr_o before arready_i.
    always_comb begin
        pc_d     = pc_q;
        araddr_d = araddr_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        kill_d   = kill_q;
        err_d    = err_q;

        accept = (state_q == DATA) && rvalid_i && !kill_q && !redirect_i;
        if (accept) begin
            inst_d   = rdata_i;
            pc_out_d = pc_q;
            err_d    = (rresp_i != RESP_OKAY);
        end

        if ((state_q == DATA) && rvalid_i) begin
            kill_d = 1'b0;
        end else if (redirect_i && ((state_q == ADDR) || (state_q == DATA))) begin
            kill_d = 1'b1;
        end

        if ((state_q == HOLD) && inst_ready_i) begin
            pc_d = pc_q + ADDR_W'(4);
        end
        if (redirect_i && (state_q != IDLE)) begin
            pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end

        if ((state_d == ADDR) && (state_q != ADDR)) begin
            araddr_d = pc_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            araddr_q <= RESET_PC;
            pc_out_q <= '0;
            inst_q   <= '0;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            araddr_q <= araddr_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            kill_q   <= kill_d;
            err_q    <= err_d;
        end
    end

    assign araddr_o    = araddr_q;
    assign pc_o        = pc_out_q;
    assign inst_o      = inst_q;
    assign fetch_err_o = err_q;

`ifdef IFU_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = (state_q == HOLD) && inst_ready_i;
    assign stall_inc = ((state_q == ADDR) && !arready_i) ||
                       ((state_q == DATA) && !rvalid_i);

    ifu_perf_cnt u_perf_cnt (
        .clk              (clk),
        .rst              (rst),
        .fetch_inc_i      (fetch_inc),
        .stall_inc_i      (stall_inc),
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: table of fetch transactions plus hand-written
// redirect and reset sequences; delivered instructions are checked against
// a scoreboard queue filled when read data is driven.
`timescale 1ns/1ps
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid_o;
    logic [31:0] araddr_o;
    logic        arready_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rready_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fetch_err_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_o;
    logic [63:0] perf_stall_cnt_o;
`endif

    always #5 clk = ~clk;

    ifu_fetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arvalid_o     (arvalid_o),
        .araddr_o      (araddr_o),
        .arready_i     (arready_i),
        .rvalid_i      (rvalid_i),
        .rdata_i       (rdata_i),
        .rresp_i       (rresp_i),
        .rready_o      (rready_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .fetch_err_o   (fetch_err_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    typedef struct {
        int unsigned arw;   // cycles arready_i held low in ADDR
        int unsigned rw;    // cycles rvalid_i held low in DATA
        int unsigned hw;    // cycles inst_ready_i held low in HOLD
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] addr;  // expected fetch address
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[7];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   hs_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_addr();
        int n = 0;
        while (!arvalid_o && n < 10) begin
            step();
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".arvalid"}, arvalid_o, 0);
        chk({tag, ".rready"}, rready_o, 0);
        chk({tag, ".inst_valid"}, inst_valid_o, 0);
        chk({tag, ".err"}, fetch_err_o, 0);
        chk({tag, ".pc_o"}, pc_o, 0);
        chk({tag, ".inst_o"}, inst_o, 0);
        chk({tag, ".araddr"}, araddr_o, 32'h8000_0000);
    endtask

    // Holds in HOLD for hw cycles, then accepts and checks against the scoreboard.
    task automatic deliver(input string tag, input int unsigned hw);
        logic        ok = 1'b1;
        logic [31:0] p0 = pc_o;
        logic [31:0] i0 = inst_o;
        exp_t        e;
        for (int unsigned i = 0; i < hw; i++) begin
            step();
            if (!inst_valid_o || arvalid_o || pc_o !== p0 || inst_o !== i0) ok = 1'b0;
        end
        chk({tag, ".hold_stable"}, ok, 1);
        inst_ready_i = 1'b1;
        chk({tag, ".sb_nonempty"}, sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, ".pc_o"}, pc_o, e.pc);
            chk({tag, ".inst_o"}, inst_o, e.inst);
            chk({tag, ".err"}, fetch_err_o, e.err);
        end
        hs_cyc = cyc;
        step();
        inst_ready_i = 1'b0;
        chk({tag, ".next_arvalid"}, {inst_valid_o, arvalid_o}, 2'b01);
    endtask

    // Drives one full fetch (address, data, hold/accept) with the given waits.
    task automatic fetch_one(input string tag, input vec_t v);
        logic        ok = 1'b1;
        logic [31:0] a0;
        int          t0;
        exp_t        e;
        wait_addr();
        chk({tag, ".arvalid"}, arvalid_o, 1);
        chk({tag, ".araddr"}, araddr_o, v.addr);
        a0 = araddr_o;
        t0 = cyc;
        for (int unsigned i = 0; i < v.arw; i++) begin
            step();
            if (!arvalid_o || araddr_o !== a0 || rready_o) ok = 1'b0;
        end
        arready_i = 1'b1;
        step();
        arready_i = 1'b0;
        if (!rready_o || arvalid_o) ok = 1'b0;
        for (int unsigned i = 0; i < v.rw; i++) begin
            step();
            if (!rready_o || inst_valid_o) ok = 1'b0;
        end
        rvalid_i = 1'b1;
        rdata_i  = v.data;
        rresp_i  = v.resp;
        e.pc   = v.addr;
        e.inst = v.data;
        e.err  = (v.resp != 2'b00);
        sbq.push_back(e);
        step();
        rvalid_i = 1'b0;
        rdata_i  = '0;
        rresp_i  = '0;
        chk({tag, ".channel_stable"}, ok, 1);
        chk({tag, ".inst_valid"}, inst_valid_o, 1);
        chk({tag, ".latency"}, 64'(cyc - t0), 64'(v.arw + v.rw + 2));
        deliver(tag, v.hw);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        exp_t e;
        int   prev_hs;

        tbl[0] = '{0, 0, 0, 32'h0000_0013, 2'b00, 32'h8000_0000};
        tbl[1] = '{0, 0, 0, 32'h0000_0013, 2'b00, 32'h8000_0004};
        tbl[2] = '{0, 0, 0, 32'h0000_0013, 2'b00, 32'h8000_0008};
        tbl[3] = '{3, 2, 0, 32'h0010_0093, 2'b00, 32'h8000_000C};
        tbl[4] = '{0, 0, 5, 32'h0020_8113, 2'b00, 32'h8000_0010};
        tbl[5] = '{1, 0, 0, 32'hDEAD_BEEF, 2'b10, 32'h8000_0014};
        tbl[6] = '{0, 1, 2, 32'h0000_0013, 2'b00, 32'h8000_0018};

        rst = 1'b1;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0;
        inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        #3;
        chk_reset("rst0");
        step();
        step();
        rst = 1'b0;
        chk("post_rst.idle", arvalid_o, 0);

        prev_hs = 0;
        for (int i = 0; i < 7; i++) begin
            fetch_one($sformatf("vec%0d", i), tbl[i]);
            if (i == 1 || i == 2) chk($sformatf("vec%0d.spacing", i), 64'(hs_cyc - prev_hs), 3);
            prev_hs = hs_cyc;
        end

        // A: redirect in DATA, response arrives two cycles later and is dropped
        wait_addr();
        chk("A.araddr", araddr_o, 32'h8000_001C);
        arready_i = 1'b1; step(); arready_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102; step(); redirect_i = 1'b0;
        step();
        rvalid_i = 1'b1; rdata_i = 32'hBAD0_0001; step(); rvalid_i = 1'b0;
        chk("A.dropped", inst_valid_o, 0);
        chk("A.arvalid", arvalid_o, 1);
        chk("A.araddr_new", araddr_o, 32'h8000_0100);
        v = '{0, 0, 0, 32'h0000_0113, 2'b00, 32'h8000_0100};
        fetch_one("A.after", v);

        // B: redirect in the same cycle as rvalid; no kill left behind
        wait_addr();
        arready_i = 1'b1; step(); arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'hBAD0_0002;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
        step();
        rvalid_i = 1'b0; redirect_i = 1'b0;
        chk("B.dropped", inst_valid_o, 0);
        chk("B.araddr", araddr_o, 32'h8000_0200);
        v = '{0, 0, 0, 32'h0000_0213, 2'b00, 32'h8000_0200};
        fetch_one("B.after", v);

        // C: redirect in HOLD without ready drops the held instruction
        wait_addr();
        arready_i = 1'b1; step(); arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'h0000_0033; step(); rvalid_i = 1'b0;
        chk("C.hold", inst_valid_o, 1);
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0300; step(); redirect_i = 1'b0;
        chk("C.drop", inst_valid_o, 0);
        chk("C.araddr", araddr_o, 32'h8000_0300);

        // D: redirect in HOLD with ready counts as delivered
        arready_i = 1'b1; step(); arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'h0000_0333; step(); rvalid_i = 1'b0;
        e.pc = 32'h8000_0300; e.inst = 32'h0000_0333; e.err = 1'b0;
        sbq.push_back(e);
        inst_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0403;
        chk("D.valid", inst_valid_o, 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("D.pc_o", pc_o, e.pc);
            chk("D.inst_o", inst_o, e.inst);
        end
        step();
        inst_ready_i = 1'b0; redirect_i = 1'b0;
        chk("D.araddr", araddr_o, 32'h8000_0400);

        // E: back-to-back redirects in ADDR; address held, last target wins
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0500; step();
        redirect_pc_i = 32'h8000_0700; step(); redirect_i = 1'b0;
        chk("E.stable", {arvalid_o, araddr_o}, {1'b1, 32'h8000_0400});
        arready_i = 1'b1; step(); arready_i = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'hBAD0_0003; step(); rvalid_i = 1'b0;
        chk("E.dropped", inst_valid_o, 0);
        chk("E.araddr", araddr_o, 32'h8000_0700);

        // F: reset mid-DATA, then a stray rvalid while IDLE
        arready_i = 1'b1; step(); arready_i = 1'b0;
        chk("F.data", rready_o, 1);
        rst = 1'b1;
        #1;
        chk_reset("F.rst");
        step();
        rst = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'hBAD0_0004;
        step();
        rvalid_i = 1'b0;
        chk("F.state", {arvalid_o, rready_o, inst_valid_o}, 3'b100);
        v = '{0, 0, 0, 32'h0000_0513, 2'b00, 32'h8000_0000};
        fetch_one("F.after", v);

        chk("sb_drained", 64'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
